minefield_generator: RTL and testbench
======================================

Name: minefield_generator

Overview:
- Writer side of the board-data interface: fills the 15x15 `data_minesweeper` array that the game-play FSM reads.
- On a start request it clears the board, places NUM_MINES mines at pseudo-random cells using an LFSR, keeping one player-chosen cell mine-free.
- It then computes the neighbour count of every non-mine cell.
- It raises `board_valid` once the array is stable, so the game-play block can begin consuming clicks.

Parameters:
- GRID, 15, side length of the square board; cell index = y*GRID + x.
- NUM_MINES, 30, mines placed per board; legal range 1..GRID*GRID-1.
- LFSR_SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'hACE1.

Ports:
- clk_pix, in, 1, pixel clock; the only clock.
- sim_rst_n, in, 1, reset, synchronous, active-low.
- start_gen, in, 1, single-cycle request to generate a new board (driven from restart).
- safe_x, in, 4, column of the cell that must not hold a mine; sampled with start_gen.
- safe_y, in, 4, row of the safe cell; sampled with start_gen.
- data_minesweeper, out, 4 x [0:224], cell codes: 0 blank, 1-8 neighbour mine count, 10 mine.
- board_valid, out, 1, high while the array holds a complete board.
- gen_busy, out, 1, high while generation is in progress.
- gen_done, out, 1, one-cycle pulse when a board completes.

Behaviour:
- Reset (sim_rst_n=0 at a clk_pix edge):
  - all cells 0; board_valid=0, gen_busy=0, gen_done=0.
  - state=IDLE, LFSR=LFSR_SEED, placed counter=0, scan index=0.
  - Reset mid-generation aborts immediately with these same values.
- LFSR: 16-bit Galois, taps mask 16'hB400, shifts right.
  - Advances every clock in every state, including IDLE, so board randomness depends on when start_gen arrives.
- States: IDLE, CLEAR, PLACE, COUNT, DONE.
- IDLE:
  - On start_gen=1: latch safe_x/safe_y; board_valid<=0; gen_busy<=1; go to CLEAR.
  - start_gen in any other state is ignored.
- CLEAR (1 cycle): all 225 cells <=0; placed<=0; go to PLACE.
- PLACE (one candidate per cycle): candidate = LFSR[7:0].
  - The candidate is accepted if all hold: candidate<225; the cell is not already 10; candidate != safe_y*15+safe_x.
  - On accept: the cell <=10 and placed<=placed+1.
  - Rejected candidates cost one cycle and change nothing.
  - When placed reaches NUM_MINES, scan index<=0 and go to COUNT; the mine is written in the same cycle.
  - A latched safe cell outside the board (x>14 or y>14) excludes nothing.
- COUNT: exactly 225 cycles, visiting index 0..224 in order.
  - A cell holding 10 is left unchanged.
  - Otherwise the cell <= number of its in-bounds 8-neighbours equal to 10 (0..8).
  - Row 0 / row 14 / column 0 / column 14 neighbours outside the grid are not counted; there is no wrap-around.
  - Mines are final before COUNT starts, so scan order does not affect the results.
  - After index 224, go to DONE.
- DONE (1 cycle): gen_done=1, board_valid<=1, gen_busy<=0, then IDLE.
- board_valid stays 1 until the next accepted start_gen or reset.
- Latency from the start_gen edge to gen_done: 1 (CLEAR) + P (PLACE cycles, P >= NUM_MINES) + 225 (COUNT) + 1.
- During generation the array contents are partial; consumers must gate on board_valid.
- Counters:
  - placed is 8 bits.
  - Index arithmetic uses 8 bits; y*15+x is computed at 8-bit width (max 224).

Test Plan:
- Reset with sim_rst_n=0 for 2 cycles -> all 225 cells 0, board_valid=0, gen_busy=0, gen_done=0.
- NUM_MINES=30, start_gen with safe=(7,7) -> gen_done after >=257 cycles. Required board:
  - exactly 30 cells ==10 and cell 112 !=10;
  - every non-mine cell equals a reference neighbour count;
  - board_valid=1 and gen_busy=0 afterwards.
- NUM_MINES=224, safe=(0,0) -> cell 0 ==3; every other cell ==10.
- Reuse the 224-mine board and check corner/edge clipping:
  - cell (0,0) counts only (1,0), (0,1), (1,1), giving 3, not 8;
  - a board with single mine NUM_MINES=1 -> exactly 3, 5 or 8 neighbours ==1 depending on the mine's position, and all other non-mine cells ==0.
- Pulse start_gen again while gen_busy=1 -> ignored: the gen_done count for the run is 1 and the latched safe cell is unchanged.
- Assert sim_rst_n=0 during COUNT -> next cycle: all cells 0, state IDLE, board_valid=0; a new start_gen produces a complete, valid board.

Source files
------------

// File: rtl/minefield_generator.sv
// Board writer for the minesweeper game: clears the grid, scatters NUM_MINES mines
// from a free-running LFSR around one protected cell, then fills in neighbour counts.
module minefield_generator #(
    parameter int          GRID      = 15,
    parameter int          NUM_MINES = 30,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk_pix,
    input  logic       sim_rst_n,
    input  logic       start_gen,
    input  logic [3:0] safe_x,
    input  logic [3:0] safe_y,
    output logic [3:0] data_minesweeper [0:GRID*GRID-1],
    output logic       board_valid,
    output logic       gen_busy,
    output logic       gen_done
);

    localparam int          CELLS    = GRID * GRID;
    localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
    localparam logic [15:0] TAPS     = 16'hB400;
    localparam logic [3:0]  MINE     = 4'd10;
    localparam logic [7:0]  LAST_IDX = 8'(CELLS - 1);
    localparam logic [7:0]  TARGET   = 8'(NUM_MINES);
    localparam logic [3:0]  EDGE     = 4'(GRID - 1);
    localparam logic [7:0]  G8       = 8'(GRID);

    typedef enum logic [2:0] {IDLE, CLEAR, PLACE, COUNT, DONE} state_t;

    state_t      state_r;
    state_t      state_s;
    logic [15:0] lfsr_r;
    logic [3:0]  cells_r [0:CELLS-1];
    logic [7:0]  placed_r;
    logic [7:0]  scan_idx_r;
    logic [3:0]  scan_x_r;
    logic [3:0]  scan_y_r;
    logic [7:0]  safe_idx_r;
    logic        safe_en_r;
    logic        board_valid_r;
    logic        gen_busy_r;
    logic        gen_done_r;

    logic [CELLS-1:0] mine_map_s;
    logic [7:0]       cand_s;
    logic             accept_s;
    logic             has_up_s;
    logic             has_dn_s;
    logic             has_lf_s;
    logic             has_rt_s;
    logic [3:0]       nbr_cnt_s;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? TAPS : 16'h0000);
    endfunction

    // Flat mine map so neighbour and candidate lookups are single-bit selects.
    always_comb begin
        for (int i = 0; i < CELLS; i++) begin
            mine_map_s[i] = (cells_r[i] == MINE);
        end
    end

    // Candidate acceptance; an off-board safe cell protects nothing.
    always_comb begin
        cand_s = lfsr_r[7:0];
        if (cand_s <= LAST_IDX) begin
            accept_s = !mine_map_s[cand_s] && !(safe_en_r && (cand_s == safe_idx_r));
        end else begin
            accept_s = 1'b0;
        end
    end

    // Neighbour count of the scanned cell, with edge clipping (no wrap-around).
    always_comb begin
        has_up_s  = (scan_y_r != 4'd0);
        has_dn_s  = (scan_y_r != EDGE);
        has_lf_s  = (scan_x_r != 4'd0);
        has_rt_s  = (scan_x_r != EDGE);
        nbr_cnt_s = {3'd0, has_up_s && has_lf_s && mine_map_s[scan_idx_r - G8 - 8'd1]}
                  + {3'd0, has_up_s &&             mine_map_s[scan_idx_r - G8]}
                  + {3'd0, has_up_s && has_rt_s && mine_map_s[scan_idx_r - G8 + 8'd1]}
                  + {3'd0, has_lf_s &&             mine_map_s[scan_idx_r - 8'd1]}
                  + {3'd0, has_rt_s &&             mine_map_s[scan_idx_r + 8'd1]}
                  + {3'd0, has_dn_s && has_lf_s && mine_map_s[scan_idx_r + G8 - 8'd1]}
                  + {3'd0, has_dn_s &&             mine_map_s[scan_idx_r + G8]}
                  + {3'd0, has_dn_s && has_rt_s && mine_map_s[scan_idx_r + G8 + 8'd1]};
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_gen) begin
                    state_s = CLEAR;
                end else begin
                    state_s = IDLE;
                end
            end
            CLEAR: state_s = PLACE;
            PLACE: begin
                if (accept_s && ((placed_r + 8'd1) == TARGET)) begin
                    state_s = COUNT;
                end else begin
                    state_s = PLACE;
                end
            end
            COUNT: begin
                if (scan_idx_r == LAST_IDX) begin
                    state_s = DONE;
                end else begin
                    state_s = COUNT;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_pix) begin
        if (!sim_rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Free-running LFSR; start timing is the only source of board variety.
    always_ff @(posedge clk_pix) begin
        if (!sim_rst_n) begin
            lfsr_r <= SEED_EFF;
        end else begin
            lfsr_r <= lfsr_step(lfsr_r);
        end
    end

    // Board array, counters and status flags.
    always_ff @(posedge clk_pix) begin
        if (!sim_rst_n) begin
            for (int i = 0; i < CELLS; i++) begin
                cells_r[i] <= 4'd0;
            end
            placed_r      <= 8'd0;
            scan_idx_r    <= 8'd0;
            scan_x_r      <= 4'd0;
            scan_y_r      <= 4'd0;
            safe_idx_r    <= 8'd0;
            safe_en_r     <= 1'b0;
            board_valid_r <= 1'b0;
            gen_busy_r    <= 1'b0;
            gen_done_r    <= 1'b0;
        end else begin
            gen_done_r <= (state_r == COUNT) && (scan_idx_r == LAST_IDX);
            case (state_r)
                IDLE: begin
                    if (start_gen) begin
                        safe_idx_r    <= {4'd0, safe_y} * G8 + {4'd0, safe_x};
                        safe_en_r     <= (safe_x <= EDGE) && (safe_y <= EDGE);
                        board_valid_r <= 1'b0;
                        gen_busy_r    <= 1'b1;
                    end
                end
                CLEAR: begin
                    for (int i = 0; i < CELLS; i++) begin
                        cells_r[i] <= 4'd0;
                    end
                    placed_r <= 8'd0;
                end
                PLACE: begin
                    if (accept_s) begin
                        cells_r[cand_s] <= MINE;
                        placed_r        <= placed_r + 8'd1;
                        if ((placed_r + 8'd1) == TARGET) begin
                            scan_idx_r <= 8'd0;
                            scan_x_r   <= 4'd0;
                            scan_y_r   <= 4'd0;
                        end
                    end
                end
                COUNT: begin
                    if (!mine_map_s[scan_idx_r]) begin
                        cells_r[scan_idx_r] <= nbr_cnt_s;
                    end
                    scan_idx_r <= scan_idx_r + 8'd1;
                    if (scan_x_r == EDGE) begin
                        scan_x_r <= 4'd0;
                        scan_y_r <= scan_y_r + 4'd1;
                    end else begin
                        scan_x_r <= scan_x_r + 4'd1;
                    end
                end
                DONE: begin
                    board_valid_r <= 1'b1;
                    gen_busy_r    <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign data_minesweeper = cells_r;
    assign board_valid      = board_valid_r;
    assign gen_busy         = gen_busy_r;
    assign gen_done         = gen_done_r;

endmodule

// File: tb/tb_minefield_generator.sv
// Randomized bench for minefield_generator: a board model derived from the LFSR
// sequence and plain neighbour arithmetic is compared against three DUT sizes.
module tb_minefield_generator;

    localparam int CELLS = 225;
    localparam int NI    = 3;

    logic          clk_pix     = 1'b0;
    logic          sim_rst_n   = 1'b1;
    logic [NI-1:0] start_gen_v = '0;
    logic [3:0]    sx [NI];
    logic [3:0]    sy [NI];
    logic [3:0]    brd0 [0:CELLS-1];
    logic [3:0]    brd1 [0:CELLS-1];
    logic [3:0]    brd2 [0:CELLS-1];
    logic [NI-1:0] valid_v;
    logic [NI-1:0] busy_v;
    logic [NI-1:0] done_v;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [15:0] m_lfsr   = 16'hACE1;
    bit          chk_en   = 1'b0;
    logic [3:0]  exp_board [NI][CELLS];
    bit          in_gen    [NI];
    int          s_cyc     [NI];
    int          e_cyc     [NI];
    int          p_m       [NI];
    int          done_cnt  [NI];
    int          done_base [NI];

    always #5 clk_pix = ~clk_pix;

    minefield_generator #(.NUM_MINES(30)) u_m30 (
        .clk_pix(clk_pix), .sim_rst_n(sim_rst_n), .start_gen(start_gen_v[0]),
        .safe_x(sx[0]), .safe_y(sy[0]), .data_minesweeper(brd0),
        .board_valid(valid_v[0]), .gen_busy(busy_v[0]), .gen_done(done_v[0]));

    minefield_generator #(.NUM_MINES(224)) u_m224 (
        .clk_pix(clk_pix), .sim_rst_n(sim_rst_n), .start_gen(start_gen_v[1]),
        .safe_x(sx[1]), .safe_y(sy[1]), .data_minesweeper(brd1),
        .board_valid(valid_v[1]), .gen_busy(busy_v[1]), .gen_done(done_v[1]));

    minefield_generator #(.NUM_MINES(1)) u_m1 (
        .clk_pix(clk_pix), .sim_rst_n(sim_rst_n), .start_gen(start_gen_v[2]),
        .safe_x(sx[2]), .safe_y(sy[2]), .data_minesweeper(brd2),
        .board_valid(valid_v[2]), .gen_busy(busy_v[2]), .gen_done(done_v[2]));

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    function automatic int mines_of(input int g);
        case (g)
            0:       return 30;
            1:       return 224;
            default: return 1;
        endcase
    endfunction

    function automatic logic [3:0] dut_cell(input int g, input int i);
        case (g)
            0:       return brd0[i];
            1:       return brd1[i];
            default: return brd2[i];
        endcase
    endfunction

    function automatic int count_val(input int g, input int v);
        int n;
        n = 0;
        for (int i = 0; i < CELLS; i++) begin
            if (int'(dut_cell(g, i)) == v) n++;
        end
        return n;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Shadow of the free-running LFSR and a cycle counter.
    always @(posedge clk_pix) begin
        cyc <= cyc + 1;
        if (!sim_rst_n) m_lfsr <= 16'hACE1;
        else            m_lfsr <= lfsr_step(m_lfsr);
    end

    // Per-cycle comparison of every DUT against the model timeline.
    initial begin : compare
        bit ev, eb, ed;
        int bad;
        forever begin
            @(posedge clk_pix);
            #1;
            if (chk_en) begin
                for (int g = 0; g < NI; g++) begin
                    ev = in_gen[g] && (cyc > e_cyc[g]);
                    eb = in_gen[g] && (cyc > s_cyc[g]) && (cyc <= e_cyc[g]);
                    ed = in_gen[g] && (cyc == e_cyc[g]);
                    check($sformatf("board_valid[%0d]", g), int'(valid_v[g]), int'(ev));
                    check($sformatf("gen_busy[%0d]", g), int'(busy_v[g]), int'(eb));
                    check($sformatf("gen_done[%0d]", g), int'(done_v[g]), int'(ed));
                    if (done_v[g]) done_cnt[g]++;
                    if (!in_gen[g] || (cyc > e_cyc[g])) begin
                        bad = -1;
                        for (int i = 0; i < CELLS; i++) begin
                            if (bad < 0 && dut_cell(g, i) != exp_board[g][i]) bad = i;
                        end
                        n_checks++;
                        if (bad >= 0) begin
                            n_fail++;
                            $display("FAIL board[%0d] cell %0d: got %0d, expected %0d (cycle %0d)",
                                     g, bad, dut_cell(g, bad), exp_board[g][bad], cyc);
                        end
                    end
                end
            end
        end
    end

    task automatic do_reset(input int n);
        sim_rst_n = 1'b0;
        chk_en    = 1'b1;
        for (int g = 0; g < NI; g++) begin
            in_gen[g] = 1'b0;
            for (int i = 0; i < CELLS; i++) exp_board[g][i] = 4'd0;
        end
        repeat (n) @(negedge clk_pix);
        sim_rst_n = 1'b1;
    endtask

    // Issue an accepted start and predict the resulting board and timing.
    task automatic start(input int g, input logic [3:0] x, input logic [3:0] y);
        logic [15:0] l;
        int p, placed, c, si, cnt, nx, ny;
        bit safe_ok;
        start_gen_v[g] = 1'b1;
        sx[g] = x;
        sy[g] = y;
        for (int i = 0; i < CELLS; i++) exp_board[g][i] = 4'd0;
        safe_ok = (x < 4'd15) && (y < 4'd15);
        si      = int'(y) * 15 + int'(x);
        l       = lfsr_step(m_lfsr);
        p       = 0;
        placed  = 0;
        while (placed < mines_of(g) && p < 70000) begin
            l = lfsr_step(l);
            p++;
            c = int'(l[7:0]);
            if (c < CELLS && exp_board[g][c] != 4'd10 && !(safe_ok && c == si)) begin
                exp_board[g][c] = 4'd10;
                placed++;
            end
        end
        for (int yy = 0; yy < 15; yy++) begin
            for (int xx = 0; xx < 15; xx++) begin
                if (exp_board[g][yy*15+xx] != 4'd10) begin
                    cnt = 0;
                    for (int dy = -1; dy <= 1; dy++) begin
                        for (int dx = -1; dx <= 1; dx++) begin
                            nx = xx + dx;
                            ny = yy + dy;
                            if ((dx != 0 || dy != 0) && nx >= 0 && nx < 15 && ny >= 0 && ny < 15
                                && exp_board[g][ny*15+nx] == 4'd10) cnt++;
                        end
                    end
                    exp_board[g][yy*15+xx] = 4'(cnt);
                end
            end
        end
        s_cyc[g]     = cyc;
        p_m[g]       = p;
        e_cyc[g]     = cyc + p + 227;
        done_base[g] = done_cnt[g];
        in_gen[g]    = 1'b1;
        @(negedge clk_pix);
        start_gen_v[g] = 1'b0;
    endtask

    task automatic finish_gen(input int g);
        while (cyc <= e_cyc[g] + 1) @(negedge clk_pix);
        check($sformatf("done_pulses[%0d]", g), done_cnt[g] - done_base[g], 1);
    endtask

    initial begin : main
        int mpos, mx, my, edges, expn;
        for (int g = 0; g < NI; g++) begin
            sx[g] = 4'd0;
            sy[g] = 4'd0;
            in_gen[g] = 1'b0;
            done_cnt[g] = 0;
            done_base[g] = 0;
            s_cyc[g] = 0;
            e_cyc[g] = 0;
            p_m[g] = 0;
        end
        @(negedge clk_pix);
        do_reset(2);
        check("reset_nonzero_cells", CELLS - count_val(0, 0), 0);
        check("lfsr_step_ace1", int'(lfsr_step(16'hACE1)), 32'h0000E270);
        check("lfsr_step_e270", int'(lfsr_step(16'hE270)), 32'h00007138);

        // 30 mines around (7,7), with an ignored restart while busy.
        start(0, 4'd7, 4'd7);
        repeat (20) @(negedge clk_pix);
        start_gen_v[0] = 1'b1;
        sx[0] = 4'd0;
        sy[0] = 4'd0;
        @(negedge clk_pix);
        start_gen_v[0] = 1'b0;
        finish_gen(0);
        check("m30_mine_count", count_val(0, 10), 30);
        check("m30_cell112_mine", int'(dut_cell(0, 112) == 4'd10), 0);
        check("m30_valid_after", int'(valid_v[0]), 1);
        check("m30_busy_after", int'(busy_v[0]), 0);

        // Random safe cells (including off-board) and random start timing.
        for (int r = 0; r < 5; r++) begin
            repeat ($urandom_range(0, 20)) @(negedge clk_pix);
            start(0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            finish_gen(0);
            check("m30_rand_mine_count", count_val(0, 10), 30);
        end
        start(0, 4'd15, 4'd0);
        finish_gen(0);
        check("m30_offboard_mine_count", count_val(0, 10), 30);

        // Nearly full board: corner clipping at (0,0).
        start(1, 4'd0, 4'd0);
        check("model_m224_cell0", int'(exp_board[1][0]), 3);
        finish_gen(1);
        check("m224_cell0", int'(dut_cell(1, 0)), 3);
        check("m224_mine_count", count_val(1, 10), 224);

        // Single mine: 3, 5 or 8 ones depending on corner / edge / interior.
        for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(0, 40)) @(negedge clk_pix);
            start(2, 4'($urandom_range(0, 14)), 4'($urandom_range(0, 14)));
            finish_gen(2);
            check("m1_mine_count", count_val(2, 10), 1);
            mpos = -1;
            for (int i = 0; i < CELLS; i++) begin
                if (dut_cell(2, i) == 4'd10) mpos = i;
            end
            if (mpos >= 0) begin
                mx    = mpos % 15;
                my    = mpos / 15;
                edges = int'(mx == 0 || mx == 14) + int'(my == 0 || my == 14);
                expn  = (edges == 2) ? 3 : ((edges == 1) ? 5 : 8);
                check("m1_ones", count_val(2, 1), expn);
                check("m1_zeros", count_val(2, 0), 224 - expn);
            end
        end

        // Reset in the middle of COUNT, then a fresh board.
        start(0, 4'd3, 4'd11);
        while (cyc < s_cyc[0] + p_m[0] + 62) @(negedge clk_pix);
        do_reset(1);
        check("midrst_busy", int'(busy_v[0]), 0);
        check("midrst_valid", int'(valid_v[0]), 0);
        check("midrst_zero_cells", count_val(0, 0), CELLS);
        repeat (3) @(negedge clk_pix);
        start(0, 4'($urandom_range(0, 14)), 4'($urandom_range(0, 14)));
        finish_gen(0);
        check("post_rst_mine_count", count_val(0, 10), 30);
        check("post_rst_valid", int'(valid_v[0]), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
